// File: rtl/ide_bridge_pkg.sv
// Shared opcodes and FSM state type for the IDE SPI bridge.
package ide_bridge_pkg;

  localparam logic [7:0] CMD_STAT   = 8'h10;
  localparam logic [7:0] CMD_TF_RD  = 8'h11;
  localparam logic [7:0] CMD_TF_WR  = 8'h12;
  localparam logic [7:0] CMD_ACK    = 8'h13;
  localparam logic [7:0] CMD_ERR    = 8'h14;
  localparam logic [7:0] CMD_BUF_RD = 8'h15;
  localparam logic [7:0] CMD_BUF_WR = 8'h16;

  localparam logic [9:0] TF_REGS   = 10'd8;
  localparam logic [9:0] BUF_BYTES = 10'd512;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_STAT,
    ST_TF_RD,
    ST_TF_WR,
    ST_BUF_RD,
    ST_BUF_WR,
    ST_SKIP
  } bridge_state_t;

endpackage

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI byte engine: pin synchronizers, rx/tx shift registers, byte_done pulse.
module spi_byte_slave (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  output logic       byte_done,
  output logic [7:0] rx,
  output logic       abort
);

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] mosi_q;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic       sck_rise;
  logic       sck_fall;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign abort    = ss_q[1];
  assign spi_miso = tx_sr[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q     <= '0;
      ss_q      <= 2'b11;
      mosi_q    <= '0;
      bit_cnt   <= '0;
      rx        <= '0;
      byte_done <= 1'b0;
      tx_sr     <= 8'hFF;
    end else begin
      sck_q     <= {sck_q[1:0], spi_sck};
      ss_q      <= {ss_q[0], spi_ss_n};
      mosi_q    <= {mosi_q[0], spi_mosi};
      byte_done <= 1'b0;
      if (ss_q[1]) begin
        bit_cnt <= '0;
        tx_sr   <= 8'hFF;
      end else begin
        if (sck_rise) begin
          rx      <= {rx[6:0], mosi_q[1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end
        // The fall after the 8th rise must not shift: the next byte's MSB is already out.
        if (byte_done) tx_sr <= tx_data;
        else if (sck_fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/ide_spi_bridge.sv
// SPI command decoder that turns firmware byte streams into ide task file / buffer strobes.
// state     | meaning
// ST_CMD    | waiting for the command byte of a session
// ST_STAT   | every byte returns {err, req_pend}
// ST_TF_RD  | streaming task file registers 0..7
// ST_TF_WR  | writing task file registers 0..7
// ST_BUF_RD | streaming the 512-byte sector buffer out
// ST_BUF_WR | filling the 512-byte sector buffer
// ST_SKIP   | ignore the rest of the session
module ide_spi_bridge
  import ide_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       ide_req,
  output logic       ide_err,
  output logic       ide_ack,
  output logic [2:0] ide_reg_o_adr,
  input  logic [7:0] ide_reg_o,
  output logic       ide_reg_we,
  output logic [2:0] ide_reg_i_adr,
  output logic [7:0] ide_reg_i,
  output logic [8:0] ide_data_addr,
  input  logic [7:0] ide_data_o,
  output logic [7:0] ide_data_i,
  output logic       ide_data_rd,
  output logic       ide_data_we
);

  bridge_state_t state, state_nxt;
  logic [9:0] idx;
  logic       inc_q, inc_nxt, clr_idx;
  logic       req_pend;
  logic       byte_done, abort;
  logic [7:0] rx, tx_data, status;
  logic       ack_nxt, reg_we_nxt, rd_nxt, we_nxt;
  logic       err_set, err_clr, pend_clr;

  spi_byte_slave u_spi (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .tx_data  (tx_data),
    .byte_done(byte_done),
    .rx       (rx),
    .abort    (abort)
  );

  assign status        = {6'b0, ide_err, req_pend};
  assign ide_reg_o_adr = idx[2:0];
  assign ide_reg_i_adr = idx[2:0];
  assign ide_data_addr = idx[8:0];

  always_comb begin
    state_nxt  = state;
    tx_data    = 8'hFF;
    inc_nxt    = 1'b0;
    clr_idx    = 1'b0;
    ack_nxt    = 1'b0;
    reg_we_nxt = 1'b0;
    rd_nxt     = 1'b0;
    we_nxt     = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    pend_clr   = 1'b0;
    if (abort) begin
      state_nxt = ST_CMD;
      clr_idx   = 1'b1;
    end else if (byte_done) begin
      case (state)
        ST_CMD: begin
          clr_idx = 1'b1;
          case (rx)
            CMD_STAT: begin
              state_nxt = ST_STAT;
              tx_data   = status;
            end
            CMD_TF_RD: begin
              state_nxt = ST_TF_RD;
              tx_data   = ide_reg_o;
              inc_nxt   = 1'b1;
            end
            CMD_TF_WR: state_nxt = ST_TF_WR;
            CMD_ACK: begin
              state_nxt = ST_SKIP;
              ack_nxt   = 1'b1;
              err_clr   = 1'b1;
              pend_clr  = 1'b1;
            end
            CMD_ERR: begin
              state_nxt = ST_SKIP;
              ack_nxt   = 1'b1;
              err_set   = 1'b1;
              pend_clr  = 1'b1;
            end
            CMD_BUF_RD: begin
              // Address 0 was prefetched while idle, so the first byte is ready now.
              state_nxt = ST_BUF_RD;
              tx_data   = ide_data_o;
              rd_nxt    = 1'b1;
              inc_nxt   = 1'b1;
              pend_clr  = 1'b1;
            end
            CMD_BUF_WR: begin
              state_nxt = ST_BUF_WR;
              pend_clr  = 1'b1;
            end
            default: state_nxt = ST_SKIP;
          endcase
        end
        ST_STAT: tx_data = status;
        ST_TF_RD: if (idx < TF_REGS) begin
          tx_data = ide_reg_o;
          inc_nxt = 1'b1;
        end
        ST_TF_WR: if (idx < TF_REGS) begin
          reg_we_nxt = 1'b1;
          inc_nxt    = 1'b1;
        end
        ST_BUF_RD: if (idx < BUF_BYTES) begin
          tx_data = ide_data_o;
          rd_nxt  = 1'b1;
          inc_nxt = 1'b1;
        end
        ST_BUF_WR: if (idx < BUF_BYTES) begin
          we_nxt  = 1'b1;
          inc_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_CMD;
      idx         <= '0;
      inc_q       <= 1'b0;
      req_pend    <= 1'b0;
      ide_err     <= 1'b0;
      ide_ack     <= 1'b0;
      ide_reg_we  <= 1'b0;
      ide_data_rd <= 1'b0;
      ide_data_we <= 1'b0;
      ide_reg_i   <= '0;
      ide_data_i  <= '0;
    end else begin
      state       <= state_nxt;
      inc_q       <= inc_nxt;
      ide_ack     <= ack_nxt;
      ide_reg_we  <= reg_we_nxt;
      ide_data_rd <= rd_nxt;
      ide_data_we <= we_nxt;
      // idx advances the cycle after its strobe so the strobe sees the old address.
      if (clr_idx)    idx <= '0;
      else if (inc_q) idx <= idx + 10'd1;
      if (reg_we_nxt) ide_reg_i  <= rx;
      if (we_nxt)     ide_data_i <= rx;
      if (err_set)      ide_err <= 1'b1;
      else if (err_clr) ide_err <= 1'b0;
      if (ide_req)       req_pend <= 1'b1;
      else if (pend_clr) req_pend <= 1'b0;
    end
  end

endmodule
